universal_shift_reg_n: RTL and testbench

- Parametrised N-bit universal shift register built on our clocked D-stage flip-flops.
- Generalises the single-bit storage stage to a WIDTH-bit register with eight operating modes, serial in/out at both ends, and a multi-step shift sequencer with busy/done handshake.
- Sits as the top-level storage/shift datapath of the reversible universal shift register.

---
 rtl/universal_shift_reg_n.sv | 136 +++++++++++++
 tb/tb_universal_shift_reg_n.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg_n.sv
// Parametrised universal shift register with eight single-step modes and a
// multi-step sequencer that reports its progress on busy and done.
module universal_shift_reg_n #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pdata,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);
   localparam logic [AMT_W-1:0] AMT_ZERO = AMT_W'(0);

   state_t           state_r, state_s;
   logic [WIDTH-1:0] q_r, q_s;
   logic [AMT_W-1:0] cnt_r, cnt_s;
   logic [2:0]       mode_r, mode_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;

   function automatic logic [WIDTH-1:0] step_f(input logic [2:0] m,
                                               input logic [WIDTH-1:0] v,
                                               input logic sr,
                                               input logic sl);
      case (m)
         3'b000:  step_f = v;
         3'b001:  step_f = {sr, v[WIDTH-1:1]};
         3'b010:  step_f = {v[WIDTH-2:0], sl};
         3'b011:  step_f = pdata;
         3'b100:  step_f = {v[0], v[WIDTH-1:1]};
         3'b101:  step_f = {v[WIDTH-2:0], v[WIDTH-1]};
         3'b110:  step_f = {v[WIDTH-1], v[WIDTH-1:1]};
         3'b111:  step_f = {WIDTH{1'b0}};
         default: step_f = v;
      endcase
   endfunction

   // Hold, load and clear complete in one step whatever amt says.
   function automatic logic is_shift_f(input logic [2:0] m);
      case (m)
         3'b001, 3'b010, 3'b100, 3'b101, 3'b110: is_shift_f = 1'b1;
         default:                                is_shift_f = 1'b0;
      endcase
   endfunction

   // Next-state, datapath and handshake decode.
   always_comb begin
      state_s = state_r;
      q_s     = q_r;
      cnt_s   = cnt_r;
      mode_s  = mode_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               mode_s = mode;
               if (!is_shift_f(mode)) begin
                  q_s    = step_f(mode, q_r, sin_r, sin_l);
                  done_s = 1'b1;
               end else if (amt == AMT_ZERO) begin
                  done_s = 1'b1;
               end else if (amt == AMT_ONE) begin
                  q_s    = step_f(mode, q_r, sin_r, sin_l);
                  done_s = 1'b1;
               end else begin
                  q_s     = step_f(mode, q_r, sin_r, sin_l);
                  cnt_s   = amt - AMT_ONE;
                  busy_s  = 1'b1;
                  state_s = RUN;
               end
            end else if (en) begin
               q_s = step_f(mode, q_r, sin_r, sin_l);
            end else begin
               q_s = q_r;
            end
         end
         RUN: begin
            q_s = step_f(mode_r, q_r, sin_r, sin_l);
            if (cnt_r == AMT_ONE) begin
               cnt_s   = AMT_ZERO;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - AMT_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
            cnt_s   = AMT_ZERO;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         q_r     <= {WIDTH{1'b0}};
         cnt_r   <= AMT_ZERO;
         mode_r  <= 3'b000;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         q_r     <= q_s;
         cnt_r   <= cnt_s;
         mode_r  <= mode_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign q      = q_r;
   assign sout_r = q_r[0];
   assign sout_l = q_r[WIDTH-1];
   assign busy   = busy_r;
   assign done   = done_r;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Directed bench for universal_shift_reg_n (WIDTH=4, AMT_W=3).
module tb_universal_shift_reg_n;

   logic       clk = 1'b0;
   logic       rst, en, sin_r, sin_l, start;
   logic [2:0] mode, amt;
   logic [3:0] pdata, q;
   logic       sout_r, sout_l, busy, done;
   int         n_cmp = 0;
   int         n_err = 0;

   universal_shift_reg_n #(.WIDTH(4), .AMT_W(3)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
      .pdata(pdata), .start(start), .amt(amt), .q(q), .sout_r(sout_r),
      .sout_l(sout_l), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
      chk({tag, ".q"}, {28'd0, q}, {28'd0, eq});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
   endtask

   task automatic load(input logic [3:0] v);
      en = 1'b1; mode = 3'b011; pdata = v; cyc(); en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0;
      pdata = 4'b0000; start = 1'b0; amt = 3'd0;
      cyc(); cyc();
      chk3("reset", 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;

      // single steps
      en = 1'b1; mode = 3'b011; pdata = 4'b1011; cyc();
      chk("load", {28'd0, q}, 32'h0000_000b);
      chk("sout_r", {31'd0, sout_r}, 32'd1);
      chk("sout_l", {31'd0, sout_l}, 32'd1);
      mode = 3'b001; sin_r = 1'b0; cyc();
      chk("shr", {28'd0, q}, 32'h0000_0005);
      mode = 3'b011; cyc(); mode = 3'b110; cyc();
      chk("asr", {28'd0, q}, 32'h0000_000d);
      mode = 3'b010; sin_l = 1'b1; cyc();
      chk("shl", {28'd0, q}, 32'h0000_000b);
      en = 1'b0; mode = 3'b111; cyc();
      chk("en0_hold", {28'd0, q}, 32'h0000_000b);

      // asynchronous reset mid-cycle
      #2 rst = 1'b1;
      #1 chk3("async_rst", 4'b0000, 1'b0, 1'b0);
      cyc(); rst = 1'b0; cyc();
      chk("post_rst_hold", {28'd0, q}, 32'h0000_0000);
      load(4'b1011);
      en = 1'b1; mode = 3'b111; cyc(); en = 1'b0;
      chk("clear", {28'd0, q}, 32'h0000_0000);

      // rotate left by 3, mode changes during RUN
      load(4'b1000);
      start = 1'b1; mode = 3'b101; amt = 3'd3; cyc();
      chk3("rol_e0", 4'b0001, 1'b1, 1'b0);
      start = 1'b0; mode = 3'b011; pdata = 4'b1111; cyc();
      chk3("rol_e1", 4'b0010, 1'b1, 1'b0);
      mode = 3'b111; cyc();
      chk3("rol_e2", 4'b0100, 1'b0, 1'b1);
      cyc();
      chk3("rol_after", 4'b0100, 1'b0, 1'b0);

      // amt = 0
      start = 1'b1; mode = 3'b001; amt = 3'd0; cyc();
      chk3("amt0", 4'b0100, 1'b0, 1'b1);
      start = 1'b0; cyc();
      chk3("amt0_after", 4'b0100, 1'b0, 1'b0);

      // amt = 1 rotate right
      load(4'b0011);
      start = 1'b1; mode = 3'b100; amt = 3'd1; cyc();
      chk3("amt1_ror", 4'b1001, 1'b0, 1'b1);
      start = 1'b0; cyc();

      // amt = 7 arithmetic shift saturates
      load(4'b1000);
      start = 1'b1; mode = 3'b110; amt = 3'd7; cyc();
      chk3("asr7_e0", 4'b1100, 1'b1, 1'b0);
      start = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      chk3("asr7_e5", 4'b1111, 1'b1, 1'b0);
      cyc();
      chk3("asr7_e6", 4'b1111, 1'b0, 1'b1);
      cyc();

      // start pulsed while busy is dropped
      load(4'b0001);
      start = 1'b1; mode = 3'b101; amt = 3'd3; cyc();
      chk3("cont_e0", 4'b0010, 1'b1, 1'b0);
      mode = 3'b111; amt = 3'd1; cyc();
      chk3("cont_e1", 4'b0100, 1'b1, 1'b0);
      start = 1'b0; cyc();
      chk3("cont_e2", 4'b1000, 1'b0, 1'b1);
      cyc();
      chk3("cont_after", 4'b1000, 1'b0, 1'b0);

      // start held into the done cycle is accepted
      start = 1'b1; mode = 3'b100; amt = 3'd2; cyc();
      chk3("b2b_e0", 4'b0100, 1'b1, 1'b0);
      mode = 3'b101; amt = 3'd1; cyc();
      chk3("b2b_e1", 4'b0010, 1'b0, 1'b1);
      cyc();
      chk3("b2b_second", 4'b0100, 1'b0, 1'b1);
      start = 1'b0; cyc();
      chk3("b2b_after", 4'b0100, 1'b0, 1'b0);

      // abort after two of five steps
      load(4'b1111);
      start = 1'b1; mode = 3'b001; amt = 3'd5; sin_r = 1'b0; cyc();
      start = 1'b0; cyc();
      chk3("abort_pre", 4'b0011, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 chk3("abort_rst", 4'b0000, 1'b0, 1'b0);
      cyc(); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk3("abort_after", 4'b0000, 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
